verificador_pin_param: RTL and testbench

Parametrised PIN-entry and verification FSM for the automatic cashier; successor to the fixed 4-digit recibiendo_pin block. Collects DIGITOS BCD digits from the keypad strobe and compares them against the card PIN. Adds three features:
- backspace and cancel
- per-digit inactivity timeout
- configurable warning and lockout thresholds, with an attempt count that survives cancel and timeout

Sits between the keypad interface and the transaction controller.

---
 rtl/verificador_pin_param_pkg.sv | 22 ++
 rtl/verificador_pin_param_contador_timeout.sv | 36 +++
 rtl/verificador_pin_param.sv | 170 +++++++++++++++++
 tb/tb_verificador_pin_param.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verificador_pin_param_pkg.sv
// pkg_cajero: shared definitions for the cashier PIN-entry blocks.
//   estado_t        - FSM state encoding for verificador_pin_param
//   DIGITO_INVALIDO - keypad idle code
//   DIGITO_MAX      - largest valid BCD digit
//   ancho_contador  - bits needed to hold the values 0..cuenta_max
package pkg_cajero;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      RECIBIENDO  = 2'd1,
      VERIFICANDO = 2'd2,
      BLOQUEADO   = 2'd3
   } estado_t;

   localparam logic [3:0] DIGITO_INVALIDO = 4'hF;
   localparam logic [3:0] DIGITO_MAX      = 4'd9;

   function automatic int ancho_contador(input int cuenta_max);
      return (cuenta_max < 2) ? 1 : $clog2(cuenta_max + 1);
   endfunction

endpackage

// File: rtl/verificador_pin_param_contador_timeout.sv
// contador_timeout: inactivity counter for the PIN-entry session.
//   clk       in  system clock
//   reset     in  synchronous, active-high reset
//   limpiar   in  restart the count from zero (has priority)
//   habilitar in  count while high
//   expirado  out high during the cycle in which the count sits at
//                 TIMEOUT_CICLOS-1 and is neither cleared nor disabled
module contador_timeout
   import pkg_cajero::*;
#(
   parameter int TIMEOUT_CICLOS = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic limpiar,
   input  logic habilitar,
   output logic expirado
);

   localparam int CW = ancho_contador(TIMEOUT_CICLOS - 1);
   localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

   logic [CW-1:0] cuenta;

   always_ff @(posedge clk) begin
      if (reset || limpiar) begin
         cuenta <= '0;
      end else if (habilitar && (cuenta != LIMITE)) begin
         cuenta <= cuenta + 1'b1;
      end
   end

   // A strobe in the same cycle as the limit wins: the session stays alive.
   assign expirado = habilitar && !limpiar && (cuenta == LIMITE);

endmodule

// File: rtl/verificador_pin_param.sv
// verificador_pin_param: parametrised PIN entry and verification FSM.
//   clk, reset        system clock, synchronous active-high reset
//   tarjeta_recibida  card inserted (level)
//   digito_stb/digito keypad digit strobe and BCD value (>9 ignored)
//   borrar_stb        backspace strobe
//   cancelar          abort the session
//   pin_correcto      expected PIN, first digit in the MS nibble
//   pin, num_digitos  digits entered so far (right-aligned) and their count
//   intentos          failed attempts, cleared only by a match or reset
//   pin_ok, pin_incorrecto, timeout, fin  one-cycle result pulses
//   advertencia       intentos >= INTENTOS_ADV
//   bloqueo           sticky lockout, only reset clears it
// Handshake: all strobes are single-cycle, sampled on the rising edge, and
// accepted only in RECIBIENDO; there is no back-pressure.
module verificador_pin_param
   import pkg_cajero::*;
#(
   parameter int DIGITOS        = 4,
   parameter int INTENTOS_MAX   = 3,
   parameter int INTENTOS_ADV   = 2,
   parameter int TIMEOUT_CICLOS = 1000
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               tarjeta_recibida,
   input  logic                               digito_stb,
   input  logic [3:0]                         digito,
   input  logic                               borrar_stb,
   input  logic                               cancelar,
   input  logic [4*DIGITOS-1:0]               pin_correcto,
   output logic [4*DIGITOS-1:0]               pin,
   output logic [$clog2(DIGITOS+1)-1:0]       num_digitos,
   output logic [$clog2(INTENTOS_MAX+1)-1:0]  intentos,
   output logic                               pin_ok,
   output logic                               pin_incorrecto,
   output logic                               advertencia,
   output logic                               bloqueo,
   output logic                               timeout,
   output logic                               fin
);

   localparam int PW = 4 * DIGITOS;
   localparam int NW = $clog2(DIGITOS + 1);
   localparam int IW = $clog2(INTENTOS_MAX + 1);

   estado_t          estado, estado_sig;
   logic [PW-1:0]    pin_sig;
   logic [NW-1:0]    num_sig;
   logic [IW-1:0]    intentos_sig, intentos_inc;
   logic             adv_sig, bloq_sig, ok_sig, inc_sig, to_sig, fin_sig;
   logic             expirado, habilitar_tmr, limpiar_tmr;

   // Counter only runs while collecting digits; being held at zero elsewhere
   // gives the clear-on-entry behaviour for free.
   assign habilitar_tmr = (estado == RECIBIENDO);
   assign limpiar_tmr   = !habilitar_tmr || digito_stb || borrar_stb;

   contador_timeout #(
      .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
   ) u_contador_timeout (
      .clk      (clk),
      .reset    (reset),
      .limpiar  (limpiar_tmr),
      .habilitar(habilitar_tmr),
      .expirado (expirado)
   );

   assign intentos_inc = (intentos == IW'(INTENTOS_MAX)) ? intentos : intentos + 1'b1;

   always_comb begin
      estado_sig   = estado;
      pin_sig      = pin;
      num_sig      = num_digitos;
      intentos_sig = intentos;
      adv_sig      = advertencia;
      bloq_sig     = bloqueo;
      ok_sig       = 1'b0;
      inc_sig      = 1'b0;
      to_sig       = 1'b0;
      fin_sig      = 1'b0;
      case (estado)
         IDLE: begin
            pin_sig = '0;
            num_sig = '0;
            if (tarjeta_recibida) estado_sig = RECIBIENDO;
         end
         RECIBIENDO: begin
            if (cancelar) begin
               pin_sig    = '0;
               num_sig    = '0;
               fin_sig    = 1'b1;
               estado_sig = IDLE;
            end else if (borrar_stb) begin
               if (num_digitos != '0) begin
                  pin_sig = {4'h0, pin[PW-1:4]};
                  num_sig = num_digitos - 1'b1;
               end
            end else if (digito_stb) begin
               if (digito <= DIGITO_MAX) begin
                  pin_sig = {pin[PW-5:0], digito};
                  num_sig = num_digitos + 1'b1;
                  if (num_digitos == NW'(DIGITOS - 1)) estado_sig = VERIFICANDO;
               end
            end else if (expirado) begin
               pin_sig    = '0;
               num_sig    = '0;
               to_sig     = 1'b1;
               fin_sig    = 1'b1;
               estado_sig = IDLE;
            end
         end
         VERIFICANDO: begin
            if (pin == pin_correcto) begin
               // pin stays visible for the pulse cycle; IDLE clears it after.
               ok_sig       = 1'b1;
               fin_sig      = 1'b1;
               intentos_sig = '0;
               adv_sig      = 1'b0;
               estado_sig   = IDLE;
            end else begin
               inc_sig      = 1'b1;
               intentos_sig = intentos_inc;
               pin_sig      = '0;
               num_sig      = '0;
               adv_sig      = (intentos_inc >= IW'(INTENTOS_ADV));
               if (intentos_inc == IW'(INTENTOS_MAX)) begin
                  bloq_sig   = 1'b1;
                  fin_sig    = 1'b1;
                  estado_sig = BLOQUEADO;
               end else begin
                  estado_sig = RECIBIENDO;
               end
            end
         end
         BLOQUEADO: begin
            estado_sig = BLOQUEADO;
         end
         default: begin
            estado_sig = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado         <= IDLE;
         pin            <= '0;
         num_digitos    <= '0;
         intentos       <= '0;
         advertencia    <= 1'b0;
         bloqueo        <= 1'b0;
         pin_ok         <= 1'b0;
         pin_incorrecto <= 1'b0;
         timeout        <= 1'b0;
         fin            <= 1'b0;
      end else begin
         estado         <= estado_sig;
         pin            <= pin_sig;
         num_digitos    <= num_sig;
         intentos       <= intentos_sig;
         advertencia    <= adv_sig;
         bloqueo        <= bloq_sig;
         pin_ok         <= ok_sig;
         pin_incorrecto <= inc_sig;
         timeout        <= to_sig;
         fin            <= fin_sig;
      end
   end

endmodule

// File: tb/tb_verificador_pin_param.sv
// Bench for verificador_pin_param: directed vector table, hand-written corner
// sequences, randomized traffic against a digit-queue model, and a second
// instance with a 6-digit / 5-attempt configuration.
module tb_verificador_pin_param;
   import pkg_cajero::*;

   localparam int D    = 4;
   localparam int IMAX = 3;
   localparam int IADV = 2;
   localparam int T    = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic        reset, tarjeta, dstb, bstb, canc;
   logic [3:0]  dig;
   logic [15:0] pc, pin;
   logic [2:0]  num;
   logic [1:0]  intentos;
   logic        pin_ok, pin_inc, adv, bloq, tmo, fin;

   // sweep instance
   logic        reset_6, tarjeta_6, dstb_6, bstb_6, canc_6;
   logic [3:0]  dig_6;
   logic [23:0] pc_6, pin_6;
   logic [2:0]  num_6, intentos_6;
   logic        pin_ok_6, pin_inc_6, adv_6, bloq_6, tmo_6, fin_6;

   verificador_pin_param #(
      .DIGITOS(D), .INTENTOS_MAX(IMAX), .INTENTOS_ADV(IADV), .TIMEOUT_CICLOS(T)
   ) dut (
      .clk(clk), .reset(reset), .tarjeta_recibida(tarjeta), .digito_stb(dstb),
      .digito(dig), .borrar_stb(bstb), .cancelar(canc), .pin_correcto(pc),
      .pin(pin), .num_digitos(num), .intentos(intentos), .pin_ok(pin_ok),
      .pin_incorrecto(pin_inc), .advertencia(adv), .bloqueo(bloq),
      .timeout(tmo), .fin(fin)
   );

   verificador_pin_param #(
      .DIGITOS(6), .INTENTOS_MAX(5), .INTENTOS_ADV(3), .TIMEOUT_CICLOS(20)
   ) dut6 (
      .clk(clk), .reset(reset_6), .tarjeta_recibida(tarjeta_6), .digito_stb(dstb_6),
      .digito(dig_6), .borrar_stb(bstb_6), .cancelar(canc_6), .pin_correcto(pc_6),
      .pin(pin_6), .num_digitos(num_6), .intentos(intentos_6), .pin_ok(pin_ok_6),
      .pin_incorrecto(pin_inc_6), .advertencia(adv_6), .bloqueo(bloq_6),
      .timeout(tmo_6), .fin(fin_6)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_q[$];
   bit m_active, m_verify, m_locked, m_adv;
   bit m_ok, m_bad, m_to, m_fin;
   int m_tries, m_idle;

   function automatic int m_pin();
      int v = 0;
      foreach (m_q[i]) v = (v << 4) | m_q[i];
      return v;
   endfunction

   task automatic model_edge(input logic rs, input logic tj, input logic ds,
                             input logic [3:0] d, input logic bs, input logic cn,
                             input logic [15:0] pcv);
      m_ok = 0; m_bad = 0; m_to = 0; m_fin = 0;
      if (rs) begin
         m_q.delete();
         m_active = 0; m_verify = 0; m_locked = 0; m_adv = 0;
         m_tries = 0; m_idle = 0;
      end else if (m_locked) begin
         m_idle = 0;
      end else if (m_verify) begin
         m_verify = 0;
         if (m_pin() == int'(pcv)) begin
            m_ok = 1; m_fin = 1; m_tries = 0; m_adv = 0;
         end else begin
            m_bad = 1;
            m_q.delete();
            if (m_tries < IMAX) m_tries++;
            m_adv = (m_tries >= IADV);
            if (m_tries == IMAX) begin
               m_locked = 1; m_fin = 1;
            end else begin
               m_active = 1; m_idle = 0;
            end
         end
      end else if (m_active) begin
         if (cn) begin
            m_q.delete(); m_fin = 1; m_active = 0;
         end else if (bs) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            m_idle = 0;
         end else if (ds) begin
            m_idle = 0;
            if (d <= 4'd9) begin
               m_q.push_back(int'(d));
               if (m_q.size() == D) begin
                  m_active = 0; m_verify = 1;
               end
            end
         end else if (m_idle == T - 1) begin
            m_to = 1; m_fin = 1; m_q.delete(); m_active = 0;
         end else begin
            m_idle++;
         end
      end else begin
         m_q.delete();
         if (tj) begin
            m_active = 1; m_idle = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("pin", pin, m_pin());
      chk("num_digitos", num, m_q.size());
      chk("intentos", intentos, m_tries);
      chk("pin_ok", pin_ok, m_ok);
      chk("pin_incorrecto", pin_inc, m_bad);
      chk("advertencia", adv, m_adv);
      chk("bloqueo", bloq, m_locked);
      chk("timeout", tmo, m_to);
      chk("fin", fin, m_fin);
   endtask

   // ---------------- drivers ----------------
   task automatic step(input logic rs, input logic tj, input logic ds,
                       input logic [3:0] d, input logic bs, input logic cn);
      @(negedge clk);
      reset = rs; tarjeta = tj; dstb = ds; dig = d; bstb = bs; canc = cn;
      @(posedge clk);
      model_edge(rs, tj, ds, d, bs, cn, pc);
      #1;
      compare_all();
   endtask

   task automatic idle_step(input logic tj);
      step(1'b0, tj, 1'b0, DIGITO_INVALIDO, 1'b0, 1'b0);
   endtask

   task automatic key(input logic [3:0] d);
      step(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0);
   endtask

   // Steps idle until timeout rises; returns the number of edges taken.
   task automatic wait_timeout(output int n);
      n = 0;
      do begin
         idle_step(1'b0);
         n++;
      end while (!tmo && n < T + 100);
   endtask

   task automatic step6(input logic rs, input logic tj, input logic ds, input logic [3:0] d);
      @(negedge clk);
      reset_6 = rs; tarjeta_6 = tj; dstb_6 = ds; dig_6 = d; bstb_6 = 1'b0; canc_6 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        tj, ds;
      logic [3:0]  d;
      logic        bs, cn;
      logic [15:0] e_pin;
      logic [2:0]  e_num;
      logic        e_ok, e_fin;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n;
      reset = 1'b1; tarjeta = 1'b0; dstb = 1'b0; dig = DIGITO_INVALIDO;
      bstb = 1'b0; canc = 1'b0; pc = 16'h3257;
      reset_6 = 1'b1; tarjeta_6 = 1'b0; dstb_6 = 1'b0; dig_6 = DIGITO_INVALIDO;
      bstb_6 = 1'b0; canc_6 = 1'b0; pc_6 = 24'h123456;

      // reset state
      step(1'b1, 1'b0, 1'b0, DIGITO_INVALIDO, 1'b0, 1'b0);
      chk("rst_pin", pin, 0);
      chk("rst_num", num, 0);
      chk("rst_fin", fin, 0);
      chk("rst_bloqueo", bloq, 0);

      // correct PIN with backspace, including backspace at zero digits
      tbl[0] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 16'h0003, 3'd1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 16'h0032, 3'd2, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 16'h0329, 3'd3, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 16'h0032, 3'd2, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 16'h0325, 3'd3, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 16'h3257, 3'd4, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 16'h3257, 3'd4, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         step(1'b0, tbl[i].tj, tbl[i].ds, tbl[i].d, tbl[i].bs, tbl[i].cn);
         chk($sformatf("tbl%0d_pin", i), pin, tbl[i].e_pin);
         chk($sformatf("tbl%0d_num", i), num, tbl[i].e_num);
         chk($sformatf("tbl%0d_ok", i), pin_ok, tbl[i].e_ok);
         chk($sformatf("tbl%0d_fin", i), fin, tbl[i].e_fin);
      end
      chk("ok_intentos", intentos, 0);

      // lockout after three wrong PINs
      step(1'b1, 1'b0, 1'b0, DIGITO_INVALIDO, 1'b0, 1'b0);
      idle_step(1'b1);
      for (int a = 1; a <= 3; a++) begin
         repeat (4) key(4'h5);
         idle_step(1'b1);
         chk($sformatf("lock%0d_inc", a), pin_inc, 1);
         chk($sformatf("lock%0d_intentos", a), intentos, a);
         chk($sformatf("lock%0d_adv", a), adv, (a >= 2));
         chk($sformatf("lock%0d_bloqueo", a), bloq, (a == 3));
         chk($sformatf("lock%0d_fin", a), fin, (a == 3));
      end
      idle_step(1'b1);
      key(4'h3);
      step(1'b0, 1'b1, 1'b0, DIGITO_INVALIDO, 1'b0, 1'b1);
      idle_step(1'b0);
      chk("locked_bloqueo", bloq, 1);
      chk("locked_num", num, 0);
      chk("locked_fin", fin, 0);

      // timeout keeps a previous failed attempt
      step(1'b1, 1'b0, 1'b0, DIGITO_INVALIDO, 1'b0, 1'b0);
      idle_step(1'b1);
      repeat (4) key(4'h5);
      idle_step(1'b1);
      key(4'h3);
      wait_timeout(n);
      chk("to_latency", n, T);
      chk("to_fin", fin, 1);
      chk("to_num", num, 0);
      idle_step(1'b1);
      chk("to_intentos_kept", intentos, 1);

      // invalid digit restarts the inactivity count
      key(4'h3);
      repeat (500) idle_step(1'b0);
      key(4'hA);
      chk("invalid_num", num, 1);
      wait_timeout(n);
      chk("invalid_to_latency", n, T);

      // cancel beats the last digit
      idle_step(1'b1);
      key(4'h3); key(4'h2); key(4'h5);
      step(1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
      chk("cancel_fin", fin, 1);
      chk("cancel_num", num, 0);
      idle_step(1'b0);
      chk("cancel_no_ok", pin_ok, 0);
      chk("cancel_no_inc", pin_inc, 0);

      // randomized traffic against the model
      step(1'b1, 1'b0, 1'b0, DIGITO_INVALIDO, 1'b0, 1'b0);
      for (int c = 0; c < 4000; c++) begin
         logic rs, tj, ds, bs, cn;
         logic [3:0] d;
         int pos;
         if (c % 500 == 0) begin
            for (int k = 0; k < 4; k++) pc[4*k +: 4] = 4'($urandom_range(0, 9));
         end
         rs = ($urandom_range(0, 399) == 0) || (m_locked && $urandom_range(0, 49) == 0);
         tj = ($urandom_range(0, 3) != 0);
         cn = ($urandom_range(0, 79) == 0);
         bs = ($urandom_range(0, 9) == 0);
         ds = ($urandom_range(0, 1) == 1);
         pos = m_q.size();
         if (pos < D && $urandom_range(0, 4) != 0) d = pc[4*(D-1-pos) +: 4];
         else d = 4'($urandom_range(0, 15));
         step(rs, tj, ds, d, bs, cn);
      end

      // 6-digit, 5-attempt configuration
      step6(1'b1, 1'b0, 1'b0, DIGITO_INVALIDO);
      chk("p6_rst_pin", pin_6, 0);
      step6(1'b0, 1'b1, 1'b0, DIGITO_INVALIDO);
      for (int a = 1; a <= 5; a++) begin
         repeat (6) step6(1'b0, 1'b1, 1'b1, 4'h1);
         chk($sformatf("p6_%0d_pin", a), pin_6, 24'h111111);
         chk($sformatf("p6_%0d_num", a), num_6, 6);
         step6(1'b0, 1'b1, 1'b0, DIGITO_INVALIDO);
         chk($sformatf("p6_%0d_inc", a), pin_inc_6, 1);
         chk($sformatf("p6_%0d_intentos", a), intentos_6, a);
         chk($sformatf("p6_%0d_adv", a), adv_6, (a >= 3));
         chk($sformatf("p6_%0d_bloqueo", a), bloq_6, (a == 5));
         chk($sformatf("p6_%0d_fin", a), fin_6, (a == 5));
      end
      step6(1'b1, 1'b0, 1'b0, DIGITO_INVALIDO);
      step6(1'b0, 1'b1, 1'b0, DIGITO_INVALIDO);
      for (int k = 1; k <= 6; k++) step6(1'b0, 1'b1, 1'b1, 4'(k));
      chk("p6_good_pin", pin_6, 24'h123456);
      step6(1'b0, 1'b0, 1'b0, DIGITO_INVALIDO);
      chk("p6_good_ok", pin_ok_6, 1);
      chk("p6_good_fin", fin_6, 1);
      chk("p6_good_inc", pin_inc_6, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
      $fatal(1);
   end

endmodule
